alu_muldiv_r32: RTL and testbench

Multi-cycle RV32 execute unit. It performs the base integer ALU operations with a registered single-cycle latency, and the RISC-V M-extension multiply/divide/remainder operations through an iterative radix-2 datapath. The block sits in the execute stage beside the combinational base ALU. It exchanges operands and results with the issue/writeback logic over a valid/ready request and a single-pulse result strobe.

---
 rtl/alu_muldiv_r32_if.sv | 22 ++
 rtl/alu_muldiv_r32.sv | 215 +++++++++++++++++++++
 tb/tb_alu_muldiv_r32.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_r32_if.sv
// Request/result channel between issue/writeback logic and the RV32 mul/div execute unit.
interface alu_muldiv_r32_if #(parameter int dataW = 32);
   logic             in_valid;
   logic             in_ready;
   logic             mext;
   logic [3:0]       alucode;
   logic [2:0]       funct3;
   logic [dataW-1:0] A;
   logic [dataW-1:0] B;
   logic             out_valid;
   logic [dataW-1:0] result;

   modport master (
      output in_valid, mext, alucode, funct3, A, B,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, mext, alucode, funct3, A, B,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/alu_muldiv_r32.sv
// RV32 execute unit: registered base ALU ops plus iterative radix-2 M-extension
// multiply (shift-add) and restoring divide, one bit per cycle.
module alu_muldiv_r32 #(
   parameter int dataW = 32
) (
   input  logic            clk,
   input  logic            nReset,
   input  logic            flush,
   alu_muldiv_r32_if.slave bus
);
   localparam int cntW = $clog2(dataW) + 1;
   localparam int shW  = $clog2(dataW);
   localparam logic [cntW-1:0]  CNT_LAST = cntW'(dataW - 1);
   localparam logic [dataW-1:0] MOST_NEG = {1'b1, {(dataW-1){1'b0}}};

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SLT  = 4'd1;
   localparam logic [3:0] ALU_SLTU = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SSL  = 4'd6;
   localparam logic [3:0] ALU_SSR  = 4'd7;
   localparam logic [3:0] ALU_SRA  = 4'd8;
   localparam logic [3:0] ALU_CPY  = 4'd9;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_REM    = 3'b110;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   function automatic logic [dataW-1:0] base_alu(input logic [3:0]       code,
                                                 input logic [dataW-1:0] a,
                                                 input logic [dataW-1:0] b);
      logic signed [dataW-1:0] a_s;
      logic signed [dataW-1:0] b_s;
      logic [shW-1:0]          sh;
      logic [dataW-1:0]        res;
      a_s = a;
      b_s = b;
      sh  = b[shW-1:0];
      case (code)
         ALU_ADD:  res = a + b;
         ALU_SLT:  res = dataW'(a_s < b_s);
         ALU_SLTU: res = dataW'(a < b);
         ALU_AND:  res = a & b;
         ALU_OR:   res = a | b;
         ALU_XOR:  res = a ^ b;
         ALU_SSL:  res = a << sh;
         ALU_SSR:  res = a >> sh;
         ALU_SRA:  res = a_s >>> sh;
         ALU_CPY:  res = b;
         default:  res = '0;
      endcase
      return res;
   endfunction

   function automatic logic [dataW-1:0] cond_neg(input logic n, input logic [dataW-1:0] v);
      return n ? -v : v;
   endfunction

   state_t                    state_q, state_d;
   logic [cntW-1:0]           cnt_q, cnt_d;
   logic [dataW-1:0]          hi_q, hi_d;
   logic [dataW-1:0]          lo_q, lo_d;
   logic [dataW-1:0]          opb_q, opb_d;
   logic [2:0]                f3_q, f3_d;
   logic                      neg_q, neg_d;
   logic [dataW-1:0]          result_q, result_d;
   logic                      out_valid_q, out_valid_d;

   logic                      accept;
   logic                      a_neg, b_neg, sgn_a, sgn_b, neg_acc;
   logic [dataW-1:0]          mag_a, mag_b;
   logic                      div_zero, div_ovf, special;
   logic [dataW-1:0]          special_res;
   logic [dataW:0]            mul_sum, div_trial;
   logic                      div_ok;
   logic [dataW-1:0]          it_hi, it_lo;
   logic [2*dataW-1:0]        prod, prod_fix;
   logic [dataW-1:0]          fin_res;

   assign accept = bus.in_valid & bus.in_ready & ~flush;

   // Accept-time decode: operand magnitudes, final sign, divide special cases.
   always_comb begin
      a_neg   = bus.A[dataW-1];
      b_neg   = bus.B[dataW-1];
      sgn_a   = 1'b0;
      sgn_b   = 1'b0;
      neg_acc = 1'b0;
      case (bus.funct3)
         F_MULH:   begin sgn_a = 1'b1; sgn_b = 1'b1; neg_acc = a_neg ^ b_neg; end
         F_MULHSU: begin sgn_a = 1'b1;               neg_acc = a_neg;         end
         F_DIV:    begin sgn_a = 1'b1; sgn_b = 1'b1; neg_acc = a_neg ^ b_neg; end
         F_REM:    begin sgn_a = 1'b1; sgn_b = 1'b1; neg_acc = a_neg;         end
         default:  ;
      endcase
      mag_a    = cond_neg(sgn_a & a_neg, bus.A);
      mag_b    = cond_neg(sgn_b & b_neg, bus.B);
      div_zero = bus.funct3[2] && (bus.B == '0);
      div_ovf  = bus.funct3[2] && !bus.funct3[0] && (bus.A == MOST_NEG) && (bus.B == '1);
      special  = bus.mext && (div_zero || div_ovf);
      if (div_zero) special_res = bus.funct3[1] ? bus.A : '1;
      else          special_res = bus.funct3[1] ? '0 : bus.A;
   end

   // One iteration: multiplier/dividend shifts through lo_q, partial result in hi_q.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      div_trial = {hi_q, lo_q[dataW-1]} - {1'b0, opb_q};
      div_ok    = ~div_trial[dataW];
      if (f3_q[2]) begin
         it_hi = div_ok ? div_trial[dataW-1:0] : {hi_q[dataW-2:0], lo_q[dataW-1]};
         it_lo = {lo_q[dataW-2:0], div_ok};
      end else begin
         it_hi = mul_sum[dataW:1];
         it_lo = {mul_sum[0], lo_q[dataW-1:1]};
      end
      prod     = {it_hi, it_lo};
      prod_fix = neg_q ? -prod : prod;
      if (f3_q[2])            fin_res = f3_q[1] ? cond_neg(neg_q, it_hi) : cond_neg(neg_q, it_lo);
      else if (f3_q == F_MUL) fin_res = prod_fix[dataW-1:0];
      else                    fin_res = prod_fix[2*dataW-1:dataW];
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (!bus.mext || special) ? DONE : RUN;
         RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_comb begin
      bus.in_ready = (state_q == IDLE);
   end

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;

   always_comb begin
      cnt_d       = cnt_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      opb_d       = opb_q;
      f3_d        = f3_q;
      neg_d       = neg_q;
      result_d    = result_q;
      out_valid_d = 1'b0;
      if (!flush) begin
         case (state_q)
            IDLE: if (accept) begin
               cnt_d = '0;
               f3_d  = bus.funct3;
               neg_d = neg_acc;
               hi_d  = '0;
               lo_d  = mag_a;
               opb_d = mag_b;
               if (!bus.mext) begin
                  result_d    = base_alu(bus.alucode, bus.A, bus.B);
                  out_valid_d = 1'b1;
               end else if (special) begin
                  result_d    = special_res;
                  out_valid_d = 1'b1;
               end
            end
            RUN: begin
               hi_d = it_hi;
               lo_d = it_lo;
               if (cnt_q == CNT_LAST) begin
                  result_d    = fin_res;
                  out_valid_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + cntW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         opb_q       <= '0;
         f3_q        <= '0;
         neg_q       <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         opb_q       <= opb_d;
         f3_q        <= f3_d;
         neg_q       <= neg_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_alu_muldiv_r32.sv
// Directed bench for alu_muldiv_r32: base ops, M ops, divide special cases, aborts.
module tb_alu_muldiv_r32;
   localparam logic [3:0] ADD = 4'd0, SLT = 4'd1, SLTU = 4'd2, XOR_ = 4'd5;
   localparam logic [3:0] SSL = 4'd6, SSR = 4'd7, SRA = 4'd8, CPY = 4'd9;
   localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
   localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

   logic clk = 1'b0;
   logic nReset;
   logic flush;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   alu_muldiv_r32_if #(.dataW(32)) bus();
   alu_muldiv_r32 #(.dataW(32)) dut (.clk(clk), .nReset(nReset), .flush(flush), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic m, input logic [3:0] code, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
      bus.in_valid = 1'b1;
      bus.mext     = m;
      bus.alucode  = code;
      bus.funct3   = f3;
      bus.A        = a;
      bus.B        = b;
   endtask

   task automatic run_op(input string tag, input logic m, input logic [3:0] code,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
      int pulses  = 0;
      int first   = 0;
      int rdy_bad = 0;
      drive(m, code, f3, a, b);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            pulses++;
            if (first == 0) first = k;
         end
         if (bus.in_ready !== (k > lat)) rdy_bad++;
      end
      chk({tag, " result"}, bus.result, exp);
      chk({tag, " latency"}, 32'(first), 32'(lat));
      chk({tag, " pulses"}, 32'(pulses), 32'd1);
      chk({tag, " in_ready"}, 32'(rdy_bad), 32'd0);
   endtask

   initial begin
      int pulses;
      int first;
      logic rdy11;
      nReset = 1'b0;
      flush  = 1'b0;
      bus.in_valid = 1'b0;
      bus.mext = 1'b0;
      bus.alucode = '0;
      bus.funct3 = '0;
      bus.A = '0;
      bus.B = '0;
      repeat (3) @(negedge clk);
      chk("reset in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset result", bus.result, 32'd0);
      nReset = 1'b1;
      @(negedge clk);

      run_op("ADD",    1'b0, ADD,  MUL, 32'd5,          32'd7,          32'd12,         1);
      run_op("SRA",    1'b0, SRA,  MUL, 32'h8000_0000,  32'd4,          32'hF800_0000,  1);
      run_op("SSR",    1'b0, SSR,  MUL, 32'h8000_0000,  32'd4,          32'h0800_0000,  1);
      run_op("SSL",    1'b0, SSL,  MUL, 32'd1,          32'd35,         32'd8,          1);
      run_op("SLT",    1'b0, SLT,  MUL, 32'hFFFF_FFFF,  32'd1,          32'd1,          1);
      run_op("SLTU",   1'b0, SLTU, MUL, 32'hFFFF_FFFF,  32'd1,          32'd0,          1);
      run_op("XOR",    1'b0, XOR_, MUL, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  1);
      run_op("CPY",    1'b0, CPY,  MUL, 32'd3,          32'hDEAD_BEEF,  32'hDEAD_BEEF,  1);
      run_op("UNDEF",  1'b0, 4'hF, MUL, 32'd3,          32'd4,          32'd0,          1);

      run_op("MUL",    1'b1, ADD, MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,          33);
      run_op("MULH",   1'b1, ADD, MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,          33);
      run_op("MULHU",  1'b1, ADD, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,  33);
      run_op("MULHSU", 1'b1, ADD, MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  33);
      run_op("MULbig", 1'b1, ADD, MUL,    32'd123456,    32'd789,       32'd97406784,   33);
      run_op("DIV",    1'b1, ADD, DIV,    -32'sd7,       32'd2,         32'hFFFF_FFFD,  33);
      run_op("REM",    1'b1, ADD, REM,    -32'sd7,       32'd2,         32'hFFFF_FFFF,  33);
      run_op("DIVU",   1'b1, ADD, DIVU,   32'd100,       32'd7,         32'd14,         33);
      run_op("REMU",   1'b1, ADD, REMU,   32'd100,       32'd7,         32'd2,          33);

      run_op("DIVU/0", 1'b1, ADD, DIVU, 32'd10,        32'd0,         32'hFFFF_FFFF, 1);
      run_op("REM/0",  1'b1, ADD, REM,  32'd10,        32'd0,         32'd10,        1);
      run_op("DIVovf", 1'b1, ADD, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("REMovf", 1'b1, ADD, REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
      run_op("REMU",   1'b1, ADD, REMU, 32'd100,       32'd7,         32'd2,         33);

      // Flush mid-multiply: no result strobe, result retains the previous value.
      drive(1'b1, ADD, MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      pulses = 0;
      rdy11  = 1'b0;
      for (int k = 11; k <= 45; k++) begin
         @(negedge clk);
         if (k == 11) rdy11 = bus.in_ready;
         if (bus.out_valid === 1'b1) pulses++;
      end
      chk("flush in_ready", 32'(rdy11), 32'd1);
      chk("flush pulses", 32'(pulses), 32'd0);
      chk("flush result", bus.result, 32'd2);

      // Flush and request together in IDLE: request dropped.
      drive(1'b0, ADD, MUL, 32'd3, 32'd4);
      flush = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("flush+req in_ready", 32'(bus.in_ready), 32'd1);
      chk("flush+req out_valid", 32'(bus.out_valid), 32'd0);
      chk("flush+req result", bus.result, 32'd2);

      // Reset during a divide.
      drive(1'b1, ADD, DIV, -32'sd7, 32'd2);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      nReset = 1'b0;
      #1;
      chk("rst-run in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst-run out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst-run result", bus.result, 32'd0);
      @(negedge clk);
      nReset = 1'b1;
      pulses = 0;
      for (int k = 0; k < 35; k++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) pulses++;
      end
      chk("rst-run pulses", 32'(pulses), 32'd0);
      run_op("ADDpost", 1'b0, ADD, MUL, 32'd1, 32'd1, 32'd2, 1);

      // in_valid held high with A changing during RUN.
      drive(1'b1, ADD, DIVU, 32'd100, 32'd7);
      @(posedge clk);
      pulses = 0;
      first  = 0;
      for (int k = 1; k <= 40; k++) begin
         #1 bus.A = $urandom;
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            pulses++;
            if (first == 0) begin
               first = k;
               bus.in_valid = 1'b0;
            end
         end
      end
      bus.in_valid = 1'b0;
      chk("hold pulses", 32'(pulses), 32'd1);
      chk("hold latency", 32'(first), 32'd33);
      chk("hold result", bus.result, 32'd14);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
